// File: rtl/delta_coalescer_if.sv
// delta_coalescer_if: event-in / drain-out handshake bundle; master drives events and drain control, slave is the coalescer
interface delta_coalescer_if #(parameter int VID_W = 4);
  logic             in_valid;
  logic [VID_W-1:0] in_vid;
  logic [15:0]      in_delta;
  logic             in_ready;
  logic             drain_req;
  logic             out_valid;
  logic [VID_W-1:0] out_vid;
  logic [15:0]      out_delta;
  logic             out_ready;
  logic             drain_done;
  logic             busy;
  modport master (output in_valid, in_vid, in_delta, drain_req, out_ready,
                  input in_ready, out_valid, out_vid, out_delta, drain_done, busy);
  modport slave (input in_valid, in_vid, in_delta, drain_req, out_ready,
                 output in_ready, out_valid, out_vid, out_delta, drain_done, busy);
endinterface

// File: rtl/delta_coalescer.sv
// delta_coalescer: per-vertex fp16 delta accumulation bins (2-stage read/add pipeline with forwarding) drained in ascending vid order; ports clock, reset (async high), bus (slave side of delta_coalescer_if)
module delta_coalescer #(
  parameter int NUM_BINS = 16,
  parameter int VID_W = 4
) (
  input logic clock,
  input logic reset,
  delta_coalescer_if.slave bus
);
  typedef enum logic [1:0] {ACCUM, FLUSH, DRAIN, DONE} state_t;
  state_t r_state, w_next;
  logic [15:0] r_bins [NUM_BINS];
  logic [NUM_BINS-1:0] r_occ;
  logic r_s1_v, r_s2_v, r_out_v;
  logic [VID_W-1:0] r_s1_vid, r_s2_vid, r_ptr, r_out_vid;
  logic [15:0] r_s1_delta, r_s2_delta, r_s2_op, r_out_delta;
  logic [15:0] w_sum, w_wdata;
  logic w_acc, w_adv, w_last;

  // Round-half-to-even fp16 add with subnormals, inf and NaN (canonical 0x7E00).
  function automatic logic [15:0] fp_add(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] x, y;
    logic [4:0] ex, ey, d5;
    logic [13:0] mx, my, sh;
    logic [14:0] s, v;
    logic [5:0] e;
    logic rnd;
    x = a[14:0] >= b[14:0] ? a : b;
    y = a[14:0] >= b[14:0] ? b : a;
    // x has the larger magnitude, so a NaN/inf operand always shows up in x
    if (x[14:10] == 5'h1f)
      return (x[9:0] != 10'd0 || (y[14:0] == 15'h7c00 && x[15] != y[15])) ? 16'h7e00 : x;
    ex = x[14:10] == 5'd0 ? 5'd1 : x[14:10];
    ey = y[14:10] == 5'd0 ? 5'd1 : y[14:10];
    mx = {|x[14:10], x[9:0], 3'b000};
    my = {|y[14:10], y[9:0], 3'b000};
    d5 = ex - ey;
    sh = d5 > 5'd13 ? {13'd0, |my} : (my >> d5) | {13'd0, ((my >> d5) << d5) != my};
    s = x[15] == y[15] ? {1'b0, mx} + {1'b0, sh} : {1'b0, mx} - {1'b0, sh};
    if (s == 15'd0) return {x[15] & y[15], 15'd0};
    e = {1'b0, ex};
    if (s[14]) begin
      s = {1'b0, s[14:2], s[1] | s[0]};
      e = e + 6'd1;
    end
    for (int i = 0; i < 13; i++)
      if (!s[13] && e > 6'd1) begin
        s = s << 1;
        e = e - 6'd1;
      end
    if (e >= 6'd31) return {x[15], 15'h7c00};
    // a missing hidden bit at e==1 is a subnormal; the rounding carry ripples into the exponent
    v = {s[13] ? e[4:0] : 5'd0, s[12:3]};
    rnd = s[2] & (s[3] | s[1] | s[0]);
    return {x[15], v + {14'd0, rnd}};
  endfunction

  assign bus.in_ready = r_state == ACCUM && !bus.drain_req;
  assign bus.out_valid = r_out_v;
  assign bus.out_vid = r_out_vid;
  assign bus.out_delta = r_out_delta;
  assign bus.drain_done = r_state == DONE;
  assign bus.busy = !(r_state == ACCUM && !r_s1_v && !r_s2_v);
  assign w_acc = bus.in_valid && bus.in_ready;
  assign w_sum = fp_add(r_s2_op, r_s2_delta);
  assign w_wdata = w_sum[14:0] == 15'd0 ? 16'h0000 : w_sum;
  assign w_adv = r_out_v ? bus.out_ready : !r_occ[r_ptr];
  assign w_last = r_ptr == VID_W'(NUM_BINS - 1);

  always_comb begin
    w_next = r_state == ACCUM ? (bus.drain_req ? FLUSH : ACCUM) :
             r_state == FLUSH ? (!r_s1_v && !r_s2_v ? DRAIN : FLUSH) :
             r_state == DRAIN ? (w_adv && w_last ? DONE : DRAIN) : ACCUM;
  end

  always_ff @(posedge clock or posedge reset)
    if (reset) r_state <= ACCUM;
    else r_state <= w_next;

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      for (int i = 0; i < NUM_BINS; i++) r_bins[i] <= 16'h0000;
      r_occ <= '0;
      r_s1_v <= 1'b0;
      r_s2_v <= 1'b0;
      r_out_v <= 1'b0;
      r_s1_vid <= '0;
      r_s2_vid <= '0;
      r_ptr <= '0;
      r_out_vid <= '0;
      r_s1_delta <= '0;
      r_s2_delta <= '0;
      r_s2_op <= '0;
      r_out_delta <= '0;
    end else begin
      r_s1_v <= w_acc;
      if (w_acc) begin
        r_s1_vid <= bus.in_vid;
        r_s1_delta <= bus.in_delta;
      end
      r_s2_v <= r_s1_v;
      // the bin being written this edge is stale in the array, so take the in-flight sum instead
      if (r_s1_v) begin
        r_s2_vid <= r_s1_vid;
        r_s2_delta <= r_s1_delta;
        r_s2_op <= r_s2_v && r_s2_vid == r_s1_vid ? w_wdata : r_bins[r_s1_vid];
      end
      if (r_s2_v) begin
        r_bins[r_s2_vid] <= w_wdata;
        r_occ[r_s2_vid] <= |w_sum[14:0];
      end
      if (r_state == FLUSH) r_ptr <= '0;
      if (r_state == DRAIN) begin
        if (r_out_v && bus.out_ready) begin
          r_bins[r_ptr] <= 16'h0000;
          r_occ[r_ptr] <= 1'b0;
        end
        if (!r_out_v && r_occ[r_ptr]) begin
          r_out_vid <= r_ptr;
          r_out_delta <= r_bins[r_ptr];
        end
        r_out_v <= r_out_v ? !bus.out_ready : r_occ[r_ptr];
        if (w_adv) r_ptr <= r_ptr + 1'b1;
      end
    end
endmodule

// File: tb/tb_delta_coalescer.sv
// tb_delta_coalescer: directed scenario tests of delta_coalescer accumulation, forwarding, drain and reset
module tb_delta_coalescer;
  logic clock = 1'b0;
  logic reset = 1'b1;
  delta_coalescer_if #(.VID_W(4)) bus ();
  delta_coalescer #(.NUM_BINS(16), .VID_W(4)) dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;

  int vec = 0;
  int miss = 0;
  logic [19:0] q_out[$];
  int n_done, ir_bad, st_bad, n_stall, n_cyc;

  task automatic push(input logic [3:0] v, input logic [15:0] d);
    bus.in_valid = 1'b1;
    bus.in_vid = v;
    bus.in_delta = d;
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic do_drain(input int stall);
    int s;
    bit held;
    logic [3:0] hv;
    logic [15:0] hd;
    q_out.delete();
    n_done = 0; ir_bad = 0; st_bad = 0; n_stall = 0; n_cyc = -1;
    s = stall; held = 0; hv = '0; hd = '0;
    bus.drain_req = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clock); #1;
    bus.drain_req = 1'b0;
    bus.in_valid = 1'b0;
    for (int c = 0; c < 300 && n_done == 0; c++) begin
      if (bus.in_ready) ir_bad++;
      if (bus.drain_done) begin n_done++; n_cyc = c; end
      if (bus.out_valid && s > 0) begin
        if (!held) begin hv = bus.out_vid; hd = bus.out_delta; held = 1; end
        else if (bus.out_vid !== hv || bus.out_delta !== hd) st_bad++;
        s--; n_stall++;
        bus.out_ready = 1'b0;
      end else begin
        if (held && (bus.out_vid !== hv || bus.out_delta !== hd)) st_bad++;
        held = 0;
        bus.out_ready = 1'b1;
        if (bus.out_valid) q_out.push_back({bus.out_vid, bus.out_delta});
      end
      @(posedge clock); #1;
    end
    bus.out_ready = 1'b1;
    repeat (3) begin
      if (bus.drain_done) n_done++;
      @(posedge clock); #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    idle(1);
    vec++; if (bus.in_ready !== 1'b1) begin miss++; $display("FAIL reset_in_ready got %0b want 1", bus.in_ready); end
    vec++; if (bus.out_valid !== 1'b0) begin miss++; $display("FAIL reset_out_valid got %0b want 0", bus.out_valid); end
    vec++; if (bus.out_vid !== 4'd0) begin miss++; $display("FAIL reset_out_vid got %0h want 0", bus.out_vid); end
    vec++; if (bus.out_delta !== 16'h0000) begin miss++; $display("FAIL reset_out_delta got %h want 0000", bus.out_delta); end
    vec++; if (bus.drain_done !== 1'b0) begin miss++; $display("FAIL reset_drain_done got %0b want 0", bus.drain_done); end
    vec++; if (bus.busy !== 1'b0) begin miss++; $display("FAIL reset_busy got %0b want 0", bus.busy); end
  endtask

  task automatic test_basic;
    logic [19:0] got;
    push(4'd3, 16'h3C00);
    push(4'd3, 16'h3800);
    do_drain(0);
    vec++; if (q_out.size() != 1) begin miss++; $display("FAIL basic_count got %0d want 1", q_out.size()); end
    got = q_out.size() > 0 ? q_out[0] : 20'hxxxxx;
    vec++; if (got !== {4'd3, 16'h3E00}) begin miss++; $display("FAIL basic_out got %h want 33e00", got); end
    vec++; if (n_done != 1) begin miss++; $display("FAIL basic_done_pulses got %0d want 1", n_done); end
    vec++; if (ir_bad != 0) begin miss++; $display("FAIL basic_in_ready_during_drain got %0d cycles high want 0", ir_bad); end
  endtask

  task automatic test_forward;
    logic [19:0] got;
    push(4'd5, 16'h3C00);
    push(4'd5, 16'h3C00);
    push(4'd5, 16'h3C00);
    vec++; if (bus.busy !== 1'b1) begin miss++; $display("FAIL fwd_busy_inflight got %0b want 1", bus.busy); end
    idle(2);
    vec++; if (bus.busy !== 1'b0) begin miss++; $display("FAIL fwd_busy_idle got %0b want 0", bus.busy); end
    do_drain(0);
    got = q_out.size() > 0 ? q_out[0] : 20'hxxxxx;
    vec++; if (q_out.size() != 1 || got !== {4'd5, 16'h4200}) begin miss++; $display("FAIL fwd_out got %h (n=%0d) want 54200 (n=1)", got, q_out.size()); end
  endtask

  task automatic test_interleave;
    logic [19:0] exp_o [2];
    logic [19:0] got;
    exp_o[0] = {4'd1, 16'h3C00};
    exp_o[1] = {4'd2, 16'h3C00};
    push(4'd1, 16'h4000);
    push(4'd2, 16'h3C00);
    push(4'd1, 16'hBC00);
    do_drain(0);
    vec++; if (q_out.size() != 2) begin miss++; $display("FAIL ilv_count got %0d want 2", q_out.size()); end
    for (int i = 0; i < 2; i++) begin
      got = i < q_out.size() ? q_out[i] : 20'hxxxxx;
      vec++; if (got !== exp_o[i]) begin miss++; $display("FAIL ilv_out%0d got %h want %h", i, got, exp_o[i]); end
    end
  endtask

  task automatic test_cancel;
    push(4'd7, 16'h3C00);
    push(4'd7, 16'hBC00);
    idle(3);
    do_drain(0);
    vec++; if (q_out.size() != 0) begin miss++; $display("FAIL cancel_count got %0d want 0", q_out.size()); end
    vec++; if (n_done != 1) begin miss++; $display("FAIL cancel_done_pulses got %0d want 1", n_done); end
    vec++; if (n_cyc != 17) begin miss++; $display("FAIL empty_drain_len got %0d want 17", n_cyc); end
  endtask

  task automatic test_stall;
    logic [19:0] got;
    push(4'd2, 16'h4000);
    push(4'd9, 16'h3C00);
    do_drain(4);
    vec++; if (n_stall != 4) begin miss++; $display("FAIL stall_cycles got %0d want 4", n_stall); end
    vec++; if (st_bad != 0) begin miss++; $display("FAIL stall_stability got %0d changes want 0", st_bad); end
    vec++; if (ir_bad != 0) begin miss++; $display("FAIL stall_in_ready got %0d cycles high want 0", ir_bad); end
    got = q_out.size() > 0 ? q_out[0] : 20'hxxxxx;
    vec++; if (got !== {4'd2, 16'h4000}) begin miss++; $display("FAIL stall_out0 got %h want 24000", got); end
    got = q_out.size() > 1 ? q_out[1] : 20'hxxxxx;
    vec++; if (got !== {4'd9, 16'h3C00}) begin miss++; $display("FAIL stall_out1 got %h want 93c00", got); end
    do_drain(0);
    vec++; if (q_out.size() != 0) begin miss++; $display("FAIL stall_cleared got %0d outputs want 0", q_out.size()); end
  endtask

  task automatic test_arith;
    logic [19:0] got;
    push(4'd0, 16'h7BFF);
    push(4'd0, 16'h7BFF);
    push(4'd13, 16'h3C01);
    push(4'd13, 16'h1000);
    do_drain(0);
    got = q_out.size() > 0 ? q_out[0] : 20'hxxxxx;
    vec++; if (got !== {4'd0, 16'h7C00}) begin miss++; $display("FAIL overflow_out got %h want 07c00", got); end
    got = q_out.size() > 1 ? q_out[1] : 20'hxxxxx;
    vec++; if (got !== {4'd13, 16'h3C02}) begin miss++; $display("FAIL rne_tie_out got %h want d3c02", got); end
  endtask

  task automatic test_flush_inflight;
    logic [19:0] got;
    push(4'd10, 16'h3C00);
    push(4'd11, 16'h4000);
    bus.in_valid = 1'b1;
    bus.in_vid = 4'd12;
    bus.in_delta = 16'h3C00;
    bus.drain_req = 1'b1;
    #1;
    vec++; if (bus.in_ready !== 1'b0) begin miss++; $display("FAIL flush_in_ready got %0b want 0", bus.in_ready); end
    do_drain(0);
    vec++; if (q_out.size() != 2) begin miss++; $display("FAIL flush_count got %0d want 2", q_out.size()); end
    got = q_out.size() > 0 ? q_out[0] : 20'hxxxxx;
    vec++; if (got !== {4'd10, 16'h3C00}) begin miss++; $display("FAIL flush_out0 got %h want a3c00", got); end
    got = q_out.size() > 1 ? q_out[1] : 20'hxxxxx;
    vec++; if (got !== {4'd11, 16'h4000}) begin miss++; $display("FAIL flush_out1 got %h want b4000", got); end
  endtask

  task automatic test_reset_mid_drain;
    push(4'd6, 16'h3C00);
    push(4'd8, 16'h3C00);
    bus.drain_req = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clock); #1;
    bus.drain_req = 1'b0;
    for (int c = 0; c < 50 && !bus.out_valid; c++) begin @(posedge clock); #1; end
    vec++; if (bus.out_valid !== 1'b1) begin miss++; $display("FAIL rstmid_wait_valid got %0b want 1", bus.out_valid); end
    #2 reset = 1'b1;
    #1;
    vec++; if (bus.out_valid !== 1'b0) begin miss++; $display("FAIL rstmid_out_valid got %0b want 0", bus.out_valid); end
    vec++; if (bus.out_vid !== 4'd0 || bus.out_delta !== 16'h0000) begin miss++; $display("FAIL rstmid_out_data got %h/%h want 0/0000", bus.out_vid, bus.out_delta); end
    vec++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin miss++; $display("FAIL rstmid_ready_busy got %0b/%0b want 1/0", bus.in_ready, bus.busy); end
    @(posedge clock); #1;
    reset = 1'b0;
    bus.out_ready = 1'b1;
    do_drain(0);
    vec++; if (q_out.size() != 0) begin miss++; $display("FAIL rstmid_post_drain got %0d outputs want 0", q_out.size()); end
    vec++; if (n_done != 1) begin miss++; $display("FAIL rstmid_done got %0d want 1", n_done); end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_vid = '0;
    bus.in_delta = '0;
    bus.drain_req = 1'b0;
    bus.out_ready = 1'b1;
    test_reset;
    test_basic;
    test_forward;
    test_interleave;
    test_cancel;
    test_stall;
    test_arith;
    test_flush_inflight;
    test_reset_mid_drain;
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule

// File: doc/delta_coalescer.md
Name: delta_coalescer

Overview:
- Accumulation stage that feeds the fp16 adder and consumes its sum.
- Incoming graph events (vertex id, fp16 delta) are coalesced per vertex into a local bin array: each new delta is added to the bin's running value.
- On request, the bin array is drained as output events to the downstream event queue.
- Two-stage pipeline (read, add/write) with sum forwarding; one combinational fp_add instance in stage 2.

Parameters:
NUM_BINS, 16, number of vertex bins (power of two)
VID_W, 4, vertex id width, equals log2(NUM_BINS)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  input event valid
in_vid  in  VID_W  input event vertex id
in_delta  in  16  input event fp16 delta
in_ready  out  1  block accepts input event this cycle
drain_req  in  1  request to flush all occupied bins
out_valid  out  1  drained event valid
out_vid  out  VID_W  drained event vertex id
out_delta  out  16  drained accumulated fp16 value
out_ready  in  1  downstream accepts drained event
drain_done  out  1  one-cycle pulse when drain completes
busy  out  1  high unless state ACCUM with both pipeline stages empty

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset state:
  - All bins = 0x0000, all occupied = 0.
  - S1/S2 valid = 0, state = ACCUM, drain pointer = 0.
  - Outputs: in_ready=1, out_valid=0, out_vid=0, out_delta=0, drain_done=0, busy=0.
- Reset asserted mid-operation discards in-flight events and any partially completed drain.
- States: ACCUM, FLUSH, DRAIN, DONE.
- ACCUM:
  - in_ready = 1 and drain_req = 0.
  - Accept = in_valid && in_ready; accepted event loads S1 (vid, delta, valid) at the edge.
- S1 to S2 at the next edge, with operand:
  - S2 sum, if S2 valid and S2.vid == S1.vid (forwarding);
  - otherwise bins[S1.vid].
- S2:
  - sum = fp_add(operand, S2.delta).
  - At the edge, bins[S2.vid] = sum and occupied = 1.
  - Exception: if sum[14:0] == 0 (either-signed zero), store 0x0000 and set occupied = 0.
- Latency and throughput:
  - Event accepted at edge k is written at edge k+2 and visible in bins from cycle k+2.
  - Sustained throughput is one event per cycle, with back-to-back same-vid events correctly accumulated via forwarding.
- Arithmetic:
  - fp16 round-half-to-even, as produced by fp_add.
  - Overflow results (0x7C00/0xFC00) are stored unmodified; no saturation or flagging.
- State transitions:
  - ACCUM -> FLUSH when drain_req = 1. The event presented on the same cycle is not accepted (in_ready = 0).
  - FLUSH: in_ready = 0; wait until S1 and S2 are empty, then go to DRAIN with pointer = 0.
  - DRAIN, pointer p:
    - Bin p unoccupied: skip, p+1 next cycle.
    - Bin p occupied: out_valid = 1, out_vid = p, out_delta = bins[p], held stable until out_ready.
    - On handshake: bins[p] = 0x0000, occupied = 0, p+1.
    - After p = NUM_BINS-1 is handled, go to DONE.
  - DONE: drain_done = 1 for one cycle, then ACCUM.
  - drain_req is ignored outside ACCUM; level held high in DONE re-enters FLUSH on the following ACCUM cycle.
- Output registers: out_vid/out_delta are registered; out_valid stays 0 outside DRAIN.
- Empty drain: with no occupied bins, the drain takes NUM_BINS cycles in DRAIN with no out_valid.

Test Plan:
- Reset, accept (vid 3, 0x3C00) then (vid 3, 0x3800) back-to-back, drain with out_ready=1 -> exactly one output: vid 3, delta 0x3E00 (1.5); drain_done pulses once.
- Three consecutive events (vid 5, 0x3C00) -> forwarding yields bin 5 = 0x4200 (3.0), not 0x4000.
- Interleaved events vid 1 0x4000, vid 2 0x3C00, vid 1 0xBC00 -> drain outputs vid 1 0x3C00, then vid 2 0x3C00, in ascending vid order.
- Events (vid 7, 0x3C00) then (vid 7, 0xBC00) -> sum is zero, bin 7 is unoccupied, and the drain produces no output for vid 7.
- Drain with out_ready held low 4 cycles on the first occupied bin -> out_valid/out_vid/out_delta stable for those cycles; in_ready = 0 for the whole drain; bin cleared only after the handshake.
- drain_req asserted while S1 and S2 are both valid -> both events are written before DRAIN starts. Separately, async reset in mid-DRAIN -> all outputs return to reset values immediately and a subsequent drain outputs nothing.
